jtframe_sdram_arb: RTL and testbench

- Round-robin arbiter that shares the single game-side SDRAM read port among NSLOT ROM requesters (CPU, tiles, sprites, sound…).
- Sits between the game logic's per-slot ROM fetchers and the frame's SDRAM port signals: sdram_req/sdram_addr/sdram_ack/data_rdy/data_read/refresh_en.
- Holds one 32-bit result register per slot, so a slot keeps its data valid while other slots are being served.

---
 rtl/jtframe_sdram_arb_pkg.sv | 35 +++
 rtl/jtframe_sdram_arb_rr.sv | 29 ++
 rtl/jtframe_sdram_arb.sv | 167 ++++++++++++++++
 tb/tb_jtframe_sdram_arb.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_sdram_arb_pkg.sv
// Shared definitions for the SDRAM read-port arbiter.
//   arb_state_t : arbiter FSM states
//   ARB_AW/DW   : default SDRAM word-address / data widths
//   f_rr_first  : rotating first-one search used by the round-robin encoder
package jtframe_sdram_arb_pkg;

    localparam int ARB_AW   = 22;
    localparam int ARB_DW   = 32;
    localparam int MAX_SLOT = 8;
    localparam int IW       = 3;   // slot index width, enough for MAX_SLOT

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        WAIT_RDY = 2'd2
    } arb_state_t;

    // Returns {found, index}. Scans from i_start upwards, wrapping at nslot.
    // The loop runs backwards so the last hit written is the closest one.
    function automatic logic [IW:0] f_rr_first(input logic [MAX_SLOT-1:0] i_pend,
                                               input logic [IW-1:0]       i_start,
                                               input int                  nslot);
        logic [IW:0] res;
        int          idx;
        res = '0;
        for (int k = MAX_SLOT - 1; k >= 0; k--) begin
            if (k < nslot) begin
                idx = (int'(i_start) + k) % nslot;
                if (i_pend[idx]) res = {1'b1, IW'(idx)};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/jtframe_sdram_arb_rr.sv
// Combinational rotating priority encoder.
//   i_pend  : pending request mask
//   i_rr    : slot that currently holds highest priority
//   o_gnt   : first pending slot at or after i_rr (wrapping)
//   o_any   : at least one slot pending
module jtframe_sdram_arb_rr
    import jtframe_sdram_arb_pkg::*;
#(
    parameter int NSLOT = 4
) (
    input  logic [NSLOT-1:0] i_pend,
    input  logic [IW-1:0]    i_rr,
    output logic [IW-1:0]    o_gnt,
    output logic             o_any
);

    logic [MAX_SLOT-1:0] w_pend;
    logic [IW:0]         w_res;

    always_comb begin
        w_pend            = '0;
        w_pend[NSLOT-1:0] = i_pend;
    end

    assign w_res = f_rr_first(w_pend, i_rr, NSLOT);
    assign o_gnt = w_res[IW-1:0];
    assign o_any = w_res[IW];

endmodule

// File: rtl/jtframe_sdram_arb.sv
// Round-robin arbiter sharing the game-side SDRAM read port among NSLOT
// ROM fetchers. Each slot keeps its last word so it stays valid while the
// other slots are served.
//   clk, rst            : clock, async active-high reset
//   downloading         : ROM download active, arbitration suspended
//   slot_req/addr/ok/dout : per-slot request side (flattened vectors)
//   sdram_req/addr/ack  : request handshake to the SDRAM controller
//   data_rdy/data_read  : read data return
//   refresh_en          : controller may refresh (arbiter idle, nothing pending)
// Build option JTFRAME_SDRAM_ARB_PRIO_EN: slot 0 gets fixed top priority,
// slots 1..NSLOT-1 rotate among themselves.
//
// state    | meaning
// IDLE     | pick the next pending slot, or clear valids while downloading
// WAIT_ACK | sdram_req high, waiting for the controller to take it
// WAIT_RDY | request taken, waiting for the read data
module jtframe_sdram_arb
    import jtframe_sdram_arb_pkg::*;
#(
    parameter int NSLOT = 4,
    parameter int AW    = ARB_AW,
    parameter int DW    = ARB_DW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                downloading,
    input  logic [NSLOT-1:0]    slot_req,
    input  logic [NSLOT*AW-1:0] slot_addr,
    output logic [NSLOT-1:0]    slot_ok,
    output logic [NSLOT*DW-1:0] slot_dout,
    output logic                sdram_req,
    output logic [AW-1:0]       sdram_addr,
    input  logic                sdram_ack,
    input  logic                data_rdy,
    input  logic [DW-1:0]       data_read,
    output logic                refresh_en
);

    arb_state_t       r_state, w_state_nxt;
    logic [IW-1:0]    r_gnt, r_rr, w_rr_gnt, w_gnt, w_rr_next;
    logic [NSLOT-1:0] r_valid, w_ok, w_pend, w_pend_rr;
    logic [AW-1:0]    r_last_addr [NSLOT];
    logic [DW-1:0]    r_dout      [NSLOT];
    logic [AW-1:0]    r_sdram_addr, w_gnt_addr;
    logic             r_sdram_req, r_refresh_en;
    logic             w_any_rr, w_any, w_grant, w_store, w_clear, w_ack_taken;

    for (genvar i = 0; i < NSLOT; i++) begin : g_slot
        assign w_ok[i] = slot_req[i] & r_valid[i] & (slot_addr[i*AW +: AW] == r_last_addr[i]);
        assign slot_dout[i*DW +: DW] = r_dout[i];
    end

    assign w_pend = slot_req & ~w_ok;

`ifdef JTFRAME_SDRAM_ARB_PRIO_EN
    assign w_pend_rr = w_pend & {{(NSLOT-1){1'b1}}, 1'b0};
    assign w_any     = w_pend[0] | w_any_rr;
    assign w_gnt     = w_pend[0] ? '0 : w_rr_gnt;
`else
    assign w_pend_rr = w_pend;
    assign w_any     = w_any_rr;
    assign w_gnt     = w_rr_gnt;
`endif

    jtframe_sdram_arb_rr #(.NSLOT(NSLOT)) u_rr (
        .i_pend (w_pend_rr),
        .i_rr   (r_rr),
        .o_gnt  (w_rr_gnt),
        .o_any  (w_any_rr)
    );

    always_comb begin
        w_gnt_addr = '0;
        for (int i = 0; i < NSLOT; i++)
            if (w_gnt == IW'(i)) w_gnt_addr = slot_addr[i*AW +: AW];
    end

    assign w_rr_next = (r_gnt == IW'(NSLOT-1)) ? '0 : r_gnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // A simultaneous ack and rdy completes the whole transaction at once.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_store     = 1'b0;
        w_clear     = 1'b0;
        w_ack_taken = 1'b0;
        case (r_state)
            IDLE: begin
                if (downloading) begin
                    w_clear = 1'b1;
                end else if (w_any) begin
                    w_grant     = 1'b1;
                    w_state_nxt = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (sdram_ack) begin
                    w_ack_taken = 1'b1;
                    if (data_rdy) begin
                        w_store     = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = WAIT_RDY;
                    end
                end
            end
            WAIT_RDY: begin
                if (data_rdy) begin
                    w_store     = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt        <= '0;
            r_rr         <= '0;
            r_valid      <= '0;
            r_sdram_req  <= 1'b0;
            r_sdram_addr <= '0;
            r_refresh_en <= 1'b1;
            for (int i = 0; i < NSLOT; i++) begin
                r_last_addr[i] <= '0;
                r_dout[i]      <= '0;
            end
        end else begin
            // Refresh is allowed while downloading too: the arbiter issues nothing.
            if (r_state == IDLE) r_refresh_en <= downloading | ~w_any;
            if (w_grant) begin
                r_gnt        <= w_gnt;
                r_sdram_addr <= w_gnt_addr;
                r_sdram_req  <= 1'b1;
            end
            if (w_ack_taken) r_sdram_req <= 1'b0;
            if (w_clear)     r_valid     <= '0;
            if (w_store) begin
                for (int i = 0; i < NSLOT; i++) begin
                    if (r_gnt == IW'(i)) begin
                        r_dout[i]      <= data_read;
                        r_last_addr[i] <= r_sdram_addr;
                        r_valid[i]     <= 1'b1;
                    end
                end
`ifdef JTFRAME_SDRAM_ARB_PRIO_EN
                // Serving slot 0 must not disturb the rotation of the others.
                if (r_gnt != '0) r_rr <= w_rr_next;
`else
                r_rr <= w_rr_next;
`endif
            end
        end
    end

    assign slot_ok    = w_ok;
    assign sdram_req  = r_sdram_req;
    assign sdram_addr = r_sdram_addr;
    assign refresh_en = r_refresh_en;

endmodule

// File: tb/tb_jtframe_sdram_arb.sv
module tb_jtframe_sdram_arb;
    localparam int N  = 4;
    localparam int AW = 22;
    localparam int DW = 32;

    logic            clk = 1'b0, rst = 1'b1, downloading = 1'b0;
    logic            sdram_ack = 1'b0, data_rdy = 1'b0;
    logic [N-1:0]    slot_req = '0;
    logic [N*AW-1:0] slot_addr = '0;
    logic [DW-1:0]   data_read = '0;
    logic [N-1:0]    slot_ok;
    logic [N*DW-1:0] slot_dout;
    logic            sdram_req, refresh_en;
    logic [AW-1:0]   sdram_addr;

    int n_checks = 0, n_errors = 0;
    bit rand_en  = 1'b0;

    jtframe_sdram_arb #(.NSLOT(N), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .downloading(downloading),
        .slot_req(slot_req), .slot_addr(slot_addr), .slot_ok(slot_ok), .slot_dout(slot_dout),
        .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
        .data_rdy(data_rdy), .data_read(data_read), .refresh_en(refresh_en)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    logic          m_valid [N];
    logic [AW-1:0] m_laddr [N];
    logic [DW-1:0] m_data  [N];
    int            m_next = 0, m_gnt = 0;
    bit            m_busy = 0, m_acked = 0;
    logic          m_req = 0, m_refresh = 1;
    logic [AW-1:0] m_addr = '0;

    initial for (int i = 0; i < N; i++) begin
        m_valid[i] = 0; m_laddr[i] = '0; m_data[i] = '0;
    end

    function automatic logic [N-1:0] model_ok();
        logic [N-1:0] ok;
        for (int i = 0; i < N; i++)
            ok[i] = slot_req[i] && m_valid[i] && (slot_addr[i*AW +: AW] == m_laddr[i]);
        return ok;
    endfunction

    function automatic int pick(input logic [N-1:0] p);
        int s;
`ifdef JTFRAME_SDRAM_ARB_PRIO_EN
        if (p[0]) return 0;
`endif
        for (int k = 0; k < N; k++) begin
            s = (m_next + k) % N;
`ifdef JTFRAME_SDRAM_ARB_PRIO_EN
            if (s == 0) continue;
`endif
            if (p[s]) return s;
        end
        return -1;
    endfunction

    task automatic complete();
        m_data[m_gnt]  = data_read;
        m_laddr[m_gnt] = m_addr;
        m_valid[m_gnt] = 1;
`ifdef JTFRAME_SDRAM_ARB_PRIO_EN
        if (m_gnt != 0) m_next = (m_gnt + 1) % N;
`else
        m_next = (m_gnt + 1) % N;
`endif
        m_busy = 0;
    endtask

    always @(posedge clk) begin
        logic [N-1:0] pend;
        int g;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_valid[i] = 0; m_laddr[i] = '0; m_data[i] = '0;
            end
            m_next = 0; m_busy = 0; m_acked = 0; m_req = 0; m_refresh = 1; m_addr = '0;
        end else if (!m_busy) begin
            pend = slot_req & ~model_ok();
            if (downloading) begin
                for (int i = 0; i < N; i++) m_valid[i] = 0;
                m_refresh = 1;
            end else if (pend != '0) begin
                g = pick(pend);
                m_gnt = g; m_busy = 1; m_acked = 0;
                m_addr = slot_addr[g*AW +: AW];
                m_req = 1; m_refresh = 0;
            end else begin
                m_refresh = 1;
            end
        end else if (!m_acked) begin
            if (sdram_ack) begin
                m_acked = 1; m_req = 0;
                if (data_rdy) complete();
            end
        end else if (data_rdy) begin
            complete();
        end
    end

    always @(posedge clk) begin
        logic [N*DW-1:0] exp_dout;
        #1;
        for (int i = 0; i < N; i++) exp_dout[i*DW +: DW] = m_data[i];
        check("sdram_req",  sdram_req,  m_req);
        check("sdram_addr", sdram_addr, m_addr);
        check("refresh_en", refresh_en, m_refresh);
        check("slot_ok",    slot_ok,    model_ok());
        check("slot_dout",  slot_dout,  exp_dout);
    end

    // ---------------- directed helpers ----------------
    task automatic set_addr(input int i, input logic [AW-1:0] a);
        slot_addr[i*AW +: AW] = a;
    endtask

    // Called at a negedge. Waits for a request, acks after ack_dly cycles,
    // returns data rdy_dly cycles after the ack (0 = same cycle). Optionally
    // changes one slot's address while the data is outstanding.
    task automatic serve(input int ack_dly, input int rdy_dly, input logic [DW-1:0] data,
                         input int chg_slot, input logic [AW-1:0] chg_addr,
                         output logic [AW-1:0] got);
        int n = 0;
        got = '0;
        while (!sdram_req && n < 50) begin @(negedge clk); n++; end
        if (!sdram_req) begin
            check("serve_timeout", sdram_req, 1);
            return;
        end
        got = sdram_addr;
        repeat (ack_dly) @(negedge clk);
        sdram_ack = 1;
        if (rdy_dly == 0) begin data_rdy = 1; data_read = data; end
        @(negedge clk);
        sdram_ack = 0; data_rdy = 0;
        if (chg_slot >= 0) set_addr(chg_slot, chg_addr);
        if (rdy_dly > 0) begin
            repeat (rdy_dly - 1) @(negedge clk);
            data_rdy = 1; data_read = data;
            @(negedge clk);
            data_rdy = 0;
        end
    endtask

    // ---------------- random stimulus ----------------
    always @(negedge clk) begin
        if (rand_en) begin
            sdram_ack = 0; data_rdy = 0; data_read = $urandom;
            if (rst) rst = 0;
            else if ($urandom_range(0, 599) == 0) rst = 1;
            if (downloading) begin
                if ($urandom_range(0, 7) == 0) downloading = 0;
            end else if ($urandom_range(0, 299) == 0) downloading = 1;
            if (m_busy && !m_acked) begin
                case ($urandom_range(0, 7))
                    0: begin sdram_ack = 1; data_rdy = 1; end
                    1, 2: sdram_ack = 1;
                    7: data_rdy = 1;
                    default: ;
                endcase
            end else if (m_busy) begin
                if ($urandom_range(0, 3) == 0) data_rdy = 1;
            end else if ($urandom_range(0, 15) == 0) begin
                data_rdy = 1;
            end
            for (int i = 0; i < N; i++) begin
                if (!slot_req[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        slot_req[i] = 1; set_addr(i, AW'($urandom_range(0, 5)));
                    end
                end else if (slot_ok[i]) begin
                    case ($urandom_range(0, 3))
                        0: slot_req[i] = 0;
                        1: set_addr(i, AW'($urandom_range(0, 5)));
                        default: ;
                    endcase
                end else if ($urandom_range(0, 31) == 0) begin
                    set_addr(i, AW'($urandom_range(0, 5)));
                end
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [AW-1:0] got;
        logic [AW-1:0] exp_seq [$];
        int            chg;
        logic [AW-1:0] chg_a;

        repeat (2) @(negedge clk);
        check("rst_req",     sdram_req,  0);
        check("rst_addr",    sdram_addr, 0);
        check("rst_refresh", refresh_en, 1);
        check("rst_ok",      slot_ok,    0);
        check("rst_dout",    slot_dout,  0);
        rst = 0;
        @(negedge clk);

        // single fetch on slot 2
        slot_req = 4'b0100; set_addr(2, 22'h00123);
        serve(2, 3, 32'hDEADBEEF, -1, '0, got);
        check("t1_addr", got, 22'h00123);
        check("t1_ok",   slot_ok[2], 1);
        check("t1_dout", slot_dout[2*DW +: DW], 32'hDEADBEEF);
        @(negedge clk);
        check("t1_refresh", refresh_en, 1);
        slot_req = '0;

        // grant order from reset with all slots requesting
        rst = 1; @(negedge clk); rst = 0;
        for (int i = 0; i < N; i++) set_addr(i, AW'(22'h100 + i));
        slot_req = 4'hF;
`ifdef JTFRAME_SDRAM_ARB_PRIO_EN
        exp_seq = '{22'h100, 22'h101, 22'h200, 22'h102, 22'h300, 22'h103};
`else
        exp_seq = '{22'h100, 22'h101, 22'h102, 22'h103};
`endif
        foreach (exp_seq[k]) begin
            chg = -1; chg_a = '0;
`ifdef JTFRAME_SDRAM_ARB_PRIO_EN
            if (k == 1) begin chg = 0; chg_a = 22'h200; end
            if (k == 3) begin chg = 0; chg_a = 22'h300; end
`endif
            serve(1, 2, $urandom, chg, chg_a, got);
            check("order", got, exp_seq[k]);
        end
        check("order_all_ok", slot_ok, 4'hF);
        slot_req = '0;
        @(negedge clk);

        // address change while data is outstanding
        slot_req = 4'b0010; set_addr(1, 22'h10);
        serve(1, 2, 32'h11111111, 1, 22'h20, got);
        check("chg_first", got, 22'h10);
        check("chg_ok_low", slot_ok[1], 0);
        serve(1, 2, 32'h22222222, -1, '0, got);
        check("chg_refetch", got, 22'h20);
        check("chg_ok_high", slot_ok[1], 1);
        slot_req = '0;
        @(negedge clk);

        // ack and rdy in the same cycle, then one idle cycle before next grant
        set_addr(0, 22'h40); set_addr(3, 22'h43);
        slot_req = 4'b1001;
        serve(1, 0, 32'hCAFEF00D, -1, '0, got);
        check("same_req_drop", sdram_req, 0);
        @(negedge clk);
        check("same_next_grant", sdram_req, 1);
        serve(0, 1, 32'h0BADC0DE, -1, '0, got);
        check("same_both_ok", slot_ok, 4'b1001);
        slot_req = '0;
        @(negedge clk);

        // reset during WAIT_RDY
        slot_req = 4'b1000; set_addr(3, 22'h55);
        repeat (2) @(negedge clk);
        check("rstw_req", sdram_req, 1);
        sdram_ack = 1; @(negedge clk); sdram_ack = 0;
        rst = 1;
        @(negedge clk);
        check("rstw_req0",     sdram_req,  0);
        check("rstw_addr0",    sdram_addr, 0);
        check("rstw_refresh",  refresh_en, 1);
        check("rstw_dout0",    slot_dout,  0);
        slot_req = '0; rst = 0;
        @(negedge clk);
        data_rdy = 1; data_read = 32'h12345678;
        @(negedge clk);
        data_rdy = 0; slot_req = 4'b1000;
        #1 check("rstw_late_rdy", slot_ok, 0);
        serve(0, 1, 32'h87654321, -1, '0, got);
        slot_req = '0;
        @(negedge clk);

        // downloading suspends arbitration and invalidates everything
        downloading = 1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < N; i++) set_addr(i, AW'(22'h300 + i));
        slot_req = 4'hF;
        repeat (6) begin
            @(negedge clk);
            check("dl_req", sdram_req, 0);
            check("dl_ok",  slot_ok,   0);
        end
        downloading = 0;
        for (int k = 0; k < N; k++) serve(1, 1, $urandom, -1, '0, got);
        check("dl_refetched", slot_ok, 4'hF);
        slot_req = '0;
        @(negedge clk);

        rand_en = 1;
        repeat (4000) @(negedge clk);
        rand_en = 0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
